// File: rtl/seg_anim_pkg.sv
// Shared types, mode encodings and the chase animation table
// for the multi-digit 7-segment sequencer.
package seg_anim_pkg;

  localparam int ANIM_FRAMES_MAX = 32;
  localparam int ANIM_IDX_W = $clog2(ANIM_FRAMES_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [1:0] MODE_LOOP = 2'b00;
  localparam logic [1:0] MODE_PING = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Active-low patterns; 7'h7F is a blank digit.
  localparam logic [6:0] ANIM_TABLE [ANIM_FRAMES_MAX] = '{
    7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7E,
    7'h7C, 7'h78, 7'h78, 7'h78,
    7'h78, 7'h78, 7'h78, 7'h78,
    7'h78, 7'h78, 7'h78, 7'h79,
    7'h7B, 7'h7F, 7'h7F, 7'h7F
  };

endpackage

// File: rtl/seg_anim_seq_rom.sv
// Combinational frame-index to segment-pattern lookup,
// one instance per digit.
module seg_anim_rom
  import seg_anim_pkg::*;
(
  input  logic [ANIM_IDX_W-1:0] idx,
  output logic [6:0]            pat
);

  assign pat = ANIM_TABLE[idx];

endmodule

// File: rtl/seg_anim_seq.sv
// 7-segment animation sequencer: FSM, prescaler, frame stepping.
// Optional PWM dimming with SEG_ANIM_PWM_EN.
module seg_anim_seq
  import seg_anim_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int FRAMES = 32,
  parameter int PHASE  = 8,
  parameter int RATE_W = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [RATE_W-1:0]         rate,
`ifdef SEG_ANIM_PWM_EN
  input  logic [3:0]                bright,
`endif
  output logic [$clog2(FRAMES)-1:0] frame_o,
  output logic [7*DIGITS-1:0]       seg_o,
  output logic                      busy,
  output logic                      done
);

  localparam int FW = $clog2(FRAMES);
  localparam logic [FW-1:0] LAST = FW'(FRAMES - 1);

  state_t            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              up_q, up_d;
  logic              done_q, done_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic              adv, tick, dark;

  assign adv  = (state_q == RUN) && en && (mode != MODE_HOLD);
  assign tick = adv && (cnt_q >= rate);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      frame_d = '0;
      cnt_d   = '0;
      up_d    = 1'b1;
    end else if (tick) begin
      cnt_d = '0;
      unique case (1'b1)
        mode == MODE_LOOP: begin
          frame_d = frame_q + FW'(1);
          up_d    = 1'b1;
        end
        mode == MODE_PING: begin
          if (up_q) begin
            if (frame_q == LAST) begin
              frame_d = frame_q - FW'(1);
              up_d    = 1'b0;
            end else begin
              frame_d = frame_q + FW'(1);
            end
          end else begin
            if (frame_q == '0) begin
              frame_d = FW'(1);
              up_d    = 1'b1;
            end else begin
              frame_d = frame_q - FW'(1);
            end
          end
        end
        mode == MODE_ONCE: begin
          frame_d = frame_q + FW'(1);
          up_d    = 1'b1;
          if (frame_d == LAST) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (adv) begin
      cnt_d = cnt_q + RATE_W'(1);
    end
  end

`ifdef SEG_ANIM_PWM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clk) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_q + 4'd1;
  end

  assign dark = (pwm_q >= bright);
`else
  assign dark = 1'b0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [FW-1:0] idx;
    logic [6:0]    pat;
    assign idx = frame_q + FW'(k * PHASE);
    seg_anim_rom u_rom (
      .idx (ANIM_IDX_W'(idx)),
      .pat (pat)
    );
    assign seg_d[7*k +: 7] =
      (state_q == IDLE || dark) ? 7'h7F : pat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      up_q    <= 1'b1;
      done_q  <= 1'b0;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign frame_o = frame_q;
  assign seg_o   = seg_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_seg_anim_seq.sv
// Self-checking bench for seg_anim_seq: tick-count reference model
// plus directed literal checks and randomized episodes.
module tb_seg_anim_seq;

  localparam int F  = 32;
  localparam int DG = 4;
  localparam int PH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] rate = 24'd3;
  logic [4:0]  frame_o;
  logic [27:0] seg_o;
  logic        busy, done;
`ifdef SEG_ANIM_PWM_EN
  logic [3:0]  bright = 4'd9;
`endif

  seg_anim_seq dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (start),
    .mode    (mode),
    .rate    (rate),
`ifdef SEG_ANIM_PWM_EN
    .bright  (bright),
`endif
    .frame_o (frame_o),
    .seg_o   (seg_o),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(int i);
    if (i == 15) return 7'h7E;
    if (i == 16) return 7'h7C;
    if (i >= 17 && i <= 26) return 7'h78;
    if (i == 27) return 7'h79;
    if (i == 28) return 7'h7B;
    return 7'h7F;
  endfunction

  function automatic logic [27:0] exp_seg(int st, int fr, bit dk);
    logic [27:0] s;
    for (int k = 0; k < DG; k++)
      s[7*k +: 7] = (st == 0 || dk) ? 7'h7F : pat((fr + k * PH) % F);
    return s;
  endfunction

  // Frame shown after t ticks since start, for a fixed mode.
  function automatic int frame_of(int md, int t);
    int p;
    case (md)
      0: return t % F;
      1: begin
        p = t % (2 * F - 2);
        return (p < F) ? p : (2 * F - 2 - p);
      end
      2: return (t < F - 1) ? t : F - 1;
      default: return 0;
    endcase
  endfunction

  // Model: 0 idle, 1 run, 2 finished.
  int m_state = 0, m_ticks = 0, m_ph = 0, m_frame = 0, m_pwm = 0;
  bit m_done = 0;
  logic [27:0] m_seg = '1;

  always @(posedge clk) begin
    bit dk;
    dk = 0;
`ifdef SEG_ANIM_PWM_EN
    dk = (m_pwm >= int'(bright));
`endif
    if (rst) begin
      m_state = 0; m_ticks = 0; m_ph = 0; m_frame = 0;
      m_done = 0; m_seg = '1; m_pwm = 0;
    end else begin
      m_seg  = exp_seg(m_state, m_frame, dk);
      m_done = 0;
      m_pwm  = (m_pwm + 1) % 16;
      if (start) begin
        m_state = 1; m_ticks = 0; m_ph = 0; m_frame = 0;
      end else if (m_state == 1 && en && mode != 2'b11) begin
        if (m_ph >= int'(rate)) begin
          m_ph = 0;
          m_ticks++;
          m_frame = frame_of(int'(mode), m_ticks);
          if (mode == 2'b10 && m_ticks == F - 1) begin
            m_state = 2;
            m_done = 1;
          end
        end else begin
          m_ph++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_frame", 32'(frame_o), 32'(m_frame));
      chk("m_busy", 32'(busy), 32'(m_state == 1));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_seg", 32'(seg_o), 32'(m_seg));
    end
  end

  task automatic go(logic [1:0] md, logic [23:0] rt);
    mode = md; rate = rt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg_o), 32'h0FFFFFFF);
    chk("rst_frame", 32'(frame_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    chk_en = 1;
    repeat (5) @(negedge clk);
    chk("idle_seg", 32'(seg_o), 32'h0FFFFFFF);
    chk("idle_busy", 32'(busy), 0);

    // Loop, rate 3
    go(2'b00, 24'd3);
    chk("loop_busy", 32'(busy), 1);
    n = 0;
    while (frame_o != 5'd15 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("loop_reach15", 32'(n < 300), 1);
    @(negedge clk);
    chk("loop_dig0", 32'(seg_o[6:0]), 32'h7E);
    chk("loop_dig1", 32'(seg_o[13:7]), 32'h78);
    repeat (80) @(negedge clk);

    // Ping-pong, rate 0
    go(2'b01, 24'd0);
    for (int i = 1; i <= 63; i++) begin
      @(negedge clk);
      if (i == 31) chk("pp_top", 32'(frame_o), 31);
      if (i == 32) chk("pp_down", 32'(frame_o), 30);
      if (i == 62) chk("pp_bot", 32'(frame_o), 0);
      if (i == 63) chk("pp_up", 32'(frame_o), 1);
    end

    // One-shot, rate 0
    go(2'b10, 24'd0);
    repeat (30) @(negedge clk);
    chk("os_f30", 32'(frame_o), 30);
    chk("os_nodone", 32'(done), 0);
    @(negedge clk);
    chk("os_f31", 32'(frame_o), 31);
    chk("os_done", 32'(done), 1);
    chk("os_busy", 32'(busy), 0);
    @(negedge clk);
    chk("os_done_pulse", 32'(done), 0);
    chk("os_hold", 32'(frame_o), 31);
    go(2'b10, 24'd0);
    chk("os_restart", 32'(frame_o), 0);
    chk("os_rebusy", 32'(busy), 1);

    // Start coinciding with a tick
    go(2'b00, 24'd0);
    repeat (5) @(negedge clk);
    chk("tick_pre", 32'(frame_o), 5);
    go(2'b00, 24'd0);
    chk("tick_start", 32'(frame_o), 0);

    // en stall mid-frame
    go(2'b00, 24'd5);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_hold", 32'(frame_o), 0);
    @(negedge clk);
    chk("stall_tick", 32'(frame_o), 1);

    // rst right before a one-shot completion
    go(2'b10, 24'd0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rrst_done", 32'(done), 0);
    chk("rrst_busy", 32'(busy), 0);
    chk("rrst_seg", 32'(seg_o), 32'h0FFFFFFF);
    chk("rrst_frame", 32'(frame_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Randomized episodes against the model
    for (int ep = 0; ep < 60; ep++) begin
      int len;
      go(2'($urandom_range(0, 3)), 24'($urandom_range(0, 3)));
      len = $urandom_range(20, 120);
      for (int c = 0; c < len; c++) begin
        en    = ($urandom_range(0, 7) != 0);
        start = ($urandom_range(0, 59) == 0);
        rst   = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 39) == 0)
          rate = 24'($urandom_range(0, 4));
        @(negedge clk);
      end
      en = 1'b1; start = 1'b0; rst = 1'b0;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
